// File: rtl/spi_bus_arbiter.sv
// Two-port arbiter sharing one SPI byte engine: round-robin frame grant,
// chip-select setup/hold timing and one byte in flight at a time.
module spi_bus_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       WR0,
  input  logic       WR1,
  input  logic [7:0] TXD0,
  input  logic [7:0] TXD1,
  output logic       GNT0,
  output logic       GNT1,
  output logic [7:0] RXD0,
  output logic [7:0] RXD1,
  output logic       RX_VLD0,
  output logic       RX_VLD1,
  output logic       SPI_EN,
  output logic [7:0] SPI_SBUF,
  input  logic [7:0] SPI_RBUF,
  input  logic       SPI_DAT_RDY,
  input  logic       SPI_RDY,
  output logic       CSN0,
  output logic       CSN1,
  output logic       BUSY
);

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, XFER, RELEASE} state_t;

  localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);

  state_t          state_reg, state_next;
  logic            owner_reg, owner_next;
  logic            last_reg, last_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [1:0]      gnt_reg, gnt_next;
  logic            pend_reg, pend_next;
  logic [7:0]      pend_byte_reg, pend_byte_next;
  logic            drop_reg, drop_next;
  logic [7:0]      sbuf_reg, sbuf_next;
  logic            spi_en_reg, spi_en_next;
  logic [1:0][7:0] rxd_reg, rxd_next;
  logic [1:0]      rx_vld_reg, rx_vld_next;

  logic [1:0]      req, wr;
  logic [1:0][7:0] txd;
  logic            own_req, own_wr, grant;
  logic [7:0]      own_txd;

  assign req     = {REQ1, REQ0};
  assign wr      = {WR1, WR0};
  assign txd     = {TXD1, TXD0};
  assign own_req = req[owner_reg];
  assign own_wr  = wr[owner_reg];
  assign own_txd = txd[owner_reg];
  // On a tie the port that was not served last wins.
  assign grant   = (req == 2'b11) ? ~last_reg : req[1];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      cnt_reg       <= 4'd0;
      gnt_reg       <= 2'b00;
      pend_reg      <= 1'b0;
      pend_byte_reg <= 8'h00;
      drop_reg      <= 1'b0;
      sbuf_reg      <= 8'h00;
      spi_en_reg    <= 1'b0;
      rxd_reg       <= '0;
      rx_vld_reg    <= 2'b00;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      cnt_reg       <= cnt_next;
      gnt_reg       <= gnt_next;
      pend_reg      <= pend_next;
      pend_byte_reg <= pend_byte_next;
      drop_reg      <= drop_next;
      sbuf_reg      <= sbuf_next;
      spi_en_reg    <= spi_en_next;
      rxd_reg       <= rxd_next;
      rx_vld_reg    <= rx_vld_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    cnt_next       = cnt_reg;
    gnt_next       = gnt_reg;
    pend_next      = pend_reg;
    pend_byte_next = pend_byte_reg;
    drop_next      = drop_reg;
    sbuf_next      = sbuf_reg;
    spi_en_next    = 1'b0;
    rxd_next       = rxd_reg;
    rx_vld_next    = 2'b00;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          owner_next = grant;
          last_next  = grant;
          gnt_next   = grant ? 2'b10 : 2'b01;
          cnt_next   = SETUP_LAST;
          pend_next  = 1'b0;
          drop_next  = 1'b0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (cnt_reg == 4'd0) state_next = WAIT;
        else cnt_next = cnt_reg - 4'd1;
      end
      WAIT: begin
        if (pend_reg || own_wr) begin
          if (SPI_RDY) begin
            sbuf_next   = pend_reg ? pend_byte_reg : own_txd;
            spi_en_next = 1'b1;
            pend_next   = 1'b0;
            drop_next   = 1'b0;
            state_next  = XFER;
          end else if (!pend_reg) begin
            // Engine busy: keep the first byte until it can be issued.
            pend_next      = 1'b1;
            pend_byte_next = own_txd;
          end
        end else if (!own_req) begin
          gnt_next   = 2'b00;
          cnt_next   = HOLD_LAST;
          state_next = RELEASE;
        end
      end
      XFER: begin
        if (!own_req) drop_next = 1'b1;
        if (SPI_DAT_RDY) begin
          rxd_next[owner_reg]    = SPI_RBUF;
          rx_vld_next[owner_reg] = 1'b1;
          if (drop_reg || !own_req) begin
            gnt_next   = 2'b00;
            cnt_next   = HOLD_LAST;
            drop_next  = 1'b0;
            state_next = RELEASE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      RELEASE: begin
        if (cnt_reg == 4'd0) state_next = IDLE;
        else cnt_next = cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign GNT0     = gnt_reg[0];
  assign GNT1     = gnt_reg[1];
  assign CSN0     = ~gnt_reg[0];
  assign CSN1     = ~gnt_reg[1];
  assign RXD0     = rxd_reg[0];
  assign RXD1     = rxd_reg[1];
  assign RX_VLD0  = rx_vld_reg[0];
  assign RX_VLD1  = rx_vld_reg[1];
  assign SPI_EN   = spi_en_reg;
  assign SPI_SBUF = sbuf_reg;
  assign BUSY     = (state_reg != IDLE);

endmodule
